alu_multibyte_seq: RTL and testbench
====================================

# alu_multibyte_seq

Multi-cycle sequencer that performs BYTES-wide arithmetic, logic and shift operations by driving the 8-bit RAT ALU one byte lane per clock. It chains carry/borrow between lanes and accumulates the zero flag, with a START/BUSY/DONE handshake. It sits between a requester (control unit or coprocessor port) and an ALU instance; the ALU itself stays outside this block.

## Interface
- BYTES, default 4: operand width in bytes; legal range 2–8.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  request; accepted only in IDLE.
- OP  in  3  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 LSL, 7 LSR.
- OPA, OPB  in  8*BYTES  operands; sampled on the accept edge. OPB is ignored for LSL and LSR.
- CIN  in  1  shift-in bit for LSL/LSR, sampled on accept; ignored for other ops.
- BUSY  out  1  high in RUN and DONE.
- DONE  out  1  one-cycle pulse; RESULT, C_OUT and Z_OUT are valid from this cycle on.
- RESULT  out  8*BYTES  result register.
- C_OUT, Z_OUT  out  1  carry/borrow and zero flags.
- ALU_SEL  out  4; ALU_A, ALU_B  out  8; ALU_CIN  out  1: drive the ALU.
- ALU_RESULT  in  8; ALU_C, ALU_Z  in  1: combinational ALU outputs.

## Operation
- Reset values: state IDLE; BUSY, DONE, C_OUT and Z_OUT are 0; RESULT is 0; ALU_SEL is MOV (14); ALU_A, ALU_B and ALU_CIN are 0.
- FSM states:
  - IDLE: on START=1, latch OP, OPA, OPB and CIN; clear lane counter; set zero accumulator to 1; go to RUN.
  - RUN: one lane per cycle for BYTES cycles, then go to DONE.
  - DONE: DONE=1 for one cycle, then go to IDLE.
- START outside IDLE is ignored. No queueing.
- Lane order: LSL and LSR are handled below. Every other op, including LSL, runs LSB lane first (lane 0..BYTES-1). LSR runs MSB lane first.
- Per-lane ALU drive:
  - ADD: SEL 0 on the first lane, then SEL 1 (ADDC).
  - SUB: SEL 2 on the first lane, then SEL 3 (SUBC).
  - CMP: SEL 4 on the first lane, then SEL 3 (SUBC).
  - AND/OR/XOR: SEL 5/6/7 on every lane, ALU_CIN=0.
  - LSL: SEL 9 on every lane. LSR: SEL 10 on every lane.
  - ALU_CIN for the first lane: latched CIN for shifts, 0 otherwise.
  - ALU_CIN for later lanes: ALU_C registered from the previous lane.
- Capture each RUN edge:
  - Write ALU_RESULT into the current lane of RESULT, except for CMP.
  - carry register <= ALU_C.
  - zero accumulator <= accumulator AND ALU_Z.
- Completion, on the edge leaving the last lane:
  - C_OUT <= last ALU_C. This is borrow for SUB/CMP and the shifted-out bit for shifts.
  - Logic ops force C_OUT=0.
  - Z_OUT <= final accumulator. For CMP, this means A==B.
- RESULT, C_OUT and Z_OUT hold until the next accepted op overwrites them.
- CMP never modifies RESULT.
- In IDLE and DONE, the ALU outputs return to their reset values.
- Reset mid-operation (RST_N=0 in any state): at the next edge, all reset values load. No DONE is issued and the partial result is discarded.

## Timing
- Accept edge = edge E, with START=1 in IDLE.
- RUN spans cycles E+1 through E+BYTES; the ALU is combinational within each cycle.
- DONE is high during cycle E+BYTES+1. For BYTES=4, DONE appears 5 cycles after the accept edge.
- BUSY rises in the cycle after E and falls when the FSM returns to IDLE.
- Throughput: one op per BYTES+2 cycles. A new START is first accepted in the cycle after DONE.
- Arithmetic is unsigned modulo 2^(8*BYTES). C_OUT is the carry out of the MSB lane.
- Wrap-around, for example FFFF_FFFF+1, gives RESULT=0, C_OUT=1, Z_OUT=1.

## Structure
- Package alu_pkg holds:
  - ALU SEL localparams: ADD=0, ADDC=1, SUB=2, SUBC=3, CMP=4, AND=5, OR=6, XOR=7, TEST=8, LSL=9, LSR=10, ROL=11, ROR=12, ASR=13, MOV=14.
  - OP enum mb_op_t.
  - FSM enum mb_state_t {IDLE, RUN, DONE}.
- One sub-module, mb_lane_reg: a BYTES-lane operand/result register with lane-select read of OPA/OPB bytes and lane-indexed write of RESULT.
- The FSM, lane counter, carry register and zero accumulator stay in the top module.

## Test plan
All scenarios use BYTES=4 with a real ALU instance attached.
1. ADD OPA=0x0000_FFFF, OPB=0x0000_0001 -> RESULT=0x0001_0000, C=0, Z=0. DONE exactly 5 cycles after the accept edge, and BUSY high for 5 cycles.
2. ADD 0xFFFF_FFFF + 0x0000_0001 -> RESULT=0, C=1, Z=1. Then SUB 0x0000_0000 − 0x0000_0001 -> RESULT=0xFFFF_FFFF, C=1, Z=0.
3. CMP 0x1234_5678 vs 0x1234_5678 after scenario 2 -> Z=1, C=0, RESULT still 0xFFFF_FFFF. CMP 0x0000_0001 vs 0x0000_0002 -> C=1, Z=0.
4. LSL 0x8000_0001 with CIN=0 -> RESULT=0x0000_0002, C=1. LSR 0x8000_0001 with CIN=1 -> RESULT=0xC000_0000, C=1. XOR 0xA5A5_A5A5 ^ 0xA5A5_A5A5 -> RESULT=0, Z=1, C=0.
5. START held high during RUN and DONE with a different OP -> ignored, and the first result is unchanged. START in the cycle after DONE is accepted.
6. RST_N=0 for one cycle during the second lane of an ADD -> next cycle: IDLE, BUSY=0, RESULT=0, C=Z=0, ALU_SEL=14. No DONE pulse at any point.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: ALU select codes,
// requester op codes, FSM states and the latched request record.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBC = 4'd3;
  localparam logic [3:0] ALU_CMP  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_TEST = 4'd8;
  localparam logic [3:0] ALU_LSL  = 4'd9;
  localparam logic [3:0] ALU_LSR  = 4'd10;
  localparam logic [3:0] ALU_ROL  = 4'd11;
  localparam logic [3:0] ALU_ROR  = 4'd12;
  localparam logic [3:0] ALU_ASR  = 4'd13;
  localparam logic [3:0] ALU_MOV  = 4'd14;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_CMP = 3'd2, OP_AND = 3'd3,
    OP_OR  = 3'd4, OP_XOR = 3'd5, OP_LSL = 3'd6, OP_LSR = 3'd7
  } mb_op_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} mb_state_t;

  typedef struct packed {
    mb_op_t op;
    logic   cin;
  } mb_req_t;

  function automatic logic is_shift(mb_op_t op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

  function automatic logic is_logic(mb_op_t op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  // Arithmetic ops switch to their carry-chained variant after the first lane.
  function automatic logic [3:0] lane_sel(mb_op_t op, logic first);
    case (op)
      OP_ADD:  return first ? ALU_ADD : ALU_ADDC;
      OP_SUB:  return first ? ALU_SUB : ALU_SUBC;
      OP_CMP:  return first ? ALU_CMP : ALU_SUBC;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_LSL:  return ALU_LSL;
      OP_LSR:  return ALU_LSR;
      default: return ALU_MOV;
    endcase
  endfunction

endpackage

// File: rtl/mb_lane_reg.sv
// Byte-lane operand and result storage: operands load whole on accept,
// the sequencer reads one lane of each and writes one result lane per cycle.
module mb_lane_reg
  import alu_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int LW    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [BYTES-1:0][7:0] opa_i,
  input  logic [BYTES-1:0][7:0] opb_i,
  input  logic [LW-1:0]         rd_lane_i,
  output logic [7:0]            a_byte_o,
  output logic [7:0]            b_byte_o,
  input  logic                  we_i,
  input  logic [LW-1:0]         wr_lane_i,
  input  logic [7:0]            wr_byte_i,
  output logic [BYTES-1:0][7:0] result_o
);

  logic [BYTES-1:0][7:0] opa_q, opb_q, res_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (load_i) begin
      opa_q <= opa_i;
      opb_q <= opb_i;
    end
  end

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    always_ff @(posedge clk_i) begin
      if (!rst_n_i)                          res_q[g] <= 8'h00;
      else if (we_i && wr_lane_i == LW'(g))  res_q[g] <= wr_byte_i;
    end
  end

  assign a_byte_o = opa_q[rd_lane_i];
  assign b_byte_o = opb_q[rd_lane_i];
  assign result_o = res_q;

endmodule

// File: rtl/alu_multibyte_seq.sv
// Drives an external 8-bit ALU one byte lane per clock to run BYTES-wide
// arithmetic/logic/shift ops, chaining carry and accumulating the zero flag.
module alu_multibyte_seq
  import alu_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [8*BYTES-1:0] opa_i,
  input  logic [8*BYTES-1:0] opb_i,
  input  logic               cin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [8*BYTES-1:0] result_o,
  output logic               c_out_o,
  output logic               z_out_o,
  output logic [3:0]         alu_sel_o,
  output logic [7:0]         alu_a_o,
  output logic [7:0]         alu_b_o,
  output logic               alu_cin_o,
  input  logic [7:0]         alu_result_i,
  input  logic               alu_c_i,
  input  logic               alu_z_i
);

  localparam int            LW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LW-1:0] LAST = LW'(BYTES - 1);

  mb_state_t     state_q, state_d;
  mb_req_t       req_q;
  logic [LW-1:0] lane_q, phys_lane;
  logic          carry_q, zacc_q, c_out_q, z_out_q;
  logic          accept, running, first_lane, last_lane;
  logic [7:0]    a_byte, b_byte;

  assign accept     = (state_q == IDLE) && start_i;
  assign running    = (state_q == RUN);
  assign first_lane = (lane_q == '0);
  assign last_lane  = (lane_q == LAST);
  // LSR walks from the MSB lane down so the shifted bit ripples toward lane 0.
  assign phys_lane  = (req_q.op == OP_LSR) ? LAST - lane_q : lane_q;

  mb_lane_reg #(.BYTES(BYTES), .LW(LW)) u_lanes (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (accept),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .rd_lane_i (phys_lane),
    .a_byte_o  (a_byte),
    .b_byte_o  (b_byte),
    .we_i      (running && req_q.op != OP_CMP),
    .wr_lane_i (phys_lane),
    .wr_byte_i (alu_result_i),
    .result_o  (result_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)   state_d = RUN;
      RUN:     if (last_lane) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_sel_o = ALU_MOV;
    alu_a_o   = 8'h00;
    alu_b_o   = 8'h00;
    alu_cin_o = 1'b0;
    if (running) begin
      alu_sel_o = lane_sel(req_q.op, first_lane);
      alu_a_o   = a_byte;
      alu_b_o   = is_shift(req_q.op) ? 8'h00 : b_byte;
      if (first_lane) alu_cin_o = is_shift(req_q.op) & req_q.cin;
      else            alu_cin_o = ~is_logic(req_q.op) & carry_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= '{op: OP_ADD, cin: 1'b0};
      lane_q  <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      c_out_q <= 1'b0;
      z_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q   <= '{op: mb_op_t'(op_i), cin: cin_i};
        lane_q  <= '0;
        carry_q <= 1'b0;
        zacc_q  <= 1'b1;
      end else if (running) begin
        carry_q <= alu_c_i;
        zacc_q  <= zacc_q & alu_z_i;
        if (last_lane) begin
          c_out_q <= is_logic(req_q.op) ? 1'b0 : alu_c_i;
          z_out_q <= zacc_q & alu_z_i;
        end else begin
          lane_q  <= lane_q + 1'b1;
        end
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign c_out_o = c_out_q;
  assign z_out_o = z_out_q;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Sequencer bench: an 8-bit ALU model hangs off the ALU port, and every op
// is scored against whole-word arithmetic on the original operands.
module tb_alu_multibyte_seq;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa, opb;
  logic         cin;
  logic         busy, done, c_out, z_out;
  logic [W-1:0] result;
  logic [3:0]   alu_sel;
  logic [7:0]   alu_a, alu_b, alu_res;
  logic         alu_cin, alu_c, alu_z;
  logic [8:0]   alu_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_res = '0;

  // First-lane and later-lane ALU selects, indexed by op code.
  logic [3:0] sel_first [8] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
  logic [3:0] sel_later [8] = '{4'd1, 4'd3, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};

  always #5 clk = ~clk;

  alu_multibyte_seq #(.BYTES(BYTES)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
    .opa_i(opa), .opb_i(opb), .cin_i(cin),
    .busy_o(busy), .done_o(done), .result_o(result),
    .c_out_o(c_out), .z_out_o(z_out),
    .alu_sel_o(alu_sel), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_result_i(alu_res), .alu_c_i(alu_c), .alu_z_i(alu_z)
  );

  // RAT ALU: {carry, result} packed into alu_t.
  always_comb begin
    alu_t = 9'd0;
    case (alu_sel)
      4'd0:      alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:      alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      4'd2, 4'd4: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd3:      alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      4'd5:      alu_t = {1'b0, alu_a & alu_b};
      4'd6:      alu_t = {1'b0, alu_a | alu_b};
      4'd7:      alu_t = {1'b0, alu_a ^ alu_b};
      4'd9:      alu_t = {alu_a, alu_cin};
      4'd10:     alu_t = {alu_a[0], alu_cin, alu_a[7:1]};
      4'd14:     alu_t = {1'b0, alu_b};
      default:   alu_t = 9'd0;
    endcase
  end
  assign alu_res = alu_t[7:0];
  assign alu_c   = alu_t[8];
  assign alu_z   = (alu_t[7:0] == 8'h00);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic c, output logic z);
    logic [W:0] t;
    c = 1'b0;
    case (o)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; exp_res = t[W-1:0]; c = t[W]; end
      3'd1: begin exp_res = a - b; c = (a < b); end
      3'd2: c = (a < b);
      3'd3: exp_res = a & b;
      3'd4: exp_res = a | b;
      3'd5: exp_res = a ^ b;
      3'd6: {c, exp_res} = {a, ci};
      default: {exp_res, c} = {ci, a};
    endcase
    z = (o == 3'd2) ? (a == b) : (exp_res == '0);
  endtask

  // Monitors one op from the cycle after its accept edge until BUSY drops.
  task automatic finish_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic ci);
    int done_cyc = 0, done_cnt = 0, busy_cnt = 0;
    logic ec, ez, rc, rz;
    logic [W-1:0] rr = '0;
    model(o, a, b, ci, ec, ez);
    rc = 1'b0; rz = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, ".sel_first"}, 64'(alu_sel), 64'(sel_first[o]));
      if (cyc == 2) chk({tag, ".sel_later"}, 64'(alu_sel), 64'(sel_later[o]));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = cyc; rr = result; rc = c_out; rz = z_out; end
      end
      if (!busy) break;
    end
    chk({tag, ".done_cyc"}, 64'(done_cyc), 64'(BYTES + 1));
    chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, ".busy_cnt"}, 64'(busy_cnt), 64'(BYTES + 1));
    chk({tag, ".result"}, 64'(rr), 64'(exp_res));
    chk({tag, ".c"}, 64'(rc), 64'(ec));
    chk({tag, ".z"}, 64'(rz), 64'(ez));
    chk({tag, ".result_hold"}, 64'(result), 64'(exp_res));
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin = ci;
    @(posedge clk);
    #1 start = 1'b0; opa = $urandom; opb = $urandom; cin = $urandom_range(0, 1);
    finish_op(tag, o, a, b, ci);
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] ra, rb;
    logic [2:0]   ro;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; opa = '0; opb = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.cz", 64'({c_out, z_out}), 64'd0);
    chk("rst.sel", 64'(alu_sel), 64'd14);
    chk("rst.abcin", 64'({alu_a, alu_b, alu_cin}), 64'd0);
    rst_n = 1'b1;

    run_op("add_carry_lane", 3'd0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_borrow", 3'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("cmp_eq", 3'd2, 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op("cmp_lt", 3'd2, 32'h0000_0001, 32'h0000_0002, 1'b0);
    run_op("lsl", 3'd6, 32'h8000_0001, 32'h5555_5555, 1'b0);
    run_op("lsr", 3'd7, 32'h8000_0001, 32'h5555_5555, 1'b1);
    run_op("xor_zero", 3'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);

    // START held through RUN and DONE with a different op: only taken once IDLE.
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'h1111_1111; opb = 32'h2222_2222; cin = 1'b0;
    @(posedge clk);
    #1 op = 3'd4; opa = 32'h0F0F_0000; opb = 32'h0000_F0F0;
    finish_op("hold_first", 3'd0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    finish_op("hold_second", 3'd4, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = '1;
        2: rb = '0;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset during the second lane of an ADD: no DONE, state fully cleared.
    done_seen = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'h0102_0304; opb = 32'h1010_1010;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); done_seen += int'(done);
    @(negedge clk); done_seen += int'(done);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_res = '0;
    @(negedge clk);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.result", 64'(result), 64'(exp_res));
    chk("midrst.cz", 64'({c_out, z_out}), 64'd0);
    chk("midrst.sel", 64'(alu_sel), 64'd14);
    for (int k = 0; k < 8; k++) begin
      done_seen += int'(done);
      @(negedge clk);
    end
    chk("midrst.no_done", 64'(done_seen), 64'd0);
    chk("midrst.idle", 64'(busy), 64'd0);

    run_op("post_rst_add", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
